seven_segment_mux: RTL and testbench

Parametrised time-multiplexed driver for common-anode seven-segment displays with N digits. Sits between score/level logic and the board's DIGIT/DISPLAY pins. Adds a programmable refresh prescaler, tear-free frame snapshotting, leading-zero suppression, per-digit decimal points and per-digit blinking.

---
 rtl/seven_segment_mux.sv | 159 +++++++++++++++
 tb/tb_seven_segment_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode seven-segment driver with frame snapshot,
// leading-zero suppression, decimal points and blinking. Define SEVSEG_HEX_EN for A-F glyphs.
module seven_segment_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic [6:0]              DISPLAY,
    output logic                    DP,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    function automatic logic [6:0] decode_seg(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
`ifdef SEVSEG_HEX_EN
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b0000011;
            4'd12:   seg = 7'b1000110;
            4'd13:   seg = 7'b0100001;
            4'd14:   seg = 7'b0000110;
            4'd15:   seg = 7'b0001110;
`endif
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [FC_W-1:0]         r_frame_cnt;
    logic                    r_phase;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blink;
    logic                    r_sh_lz;

    logic                    w_tick;
    logic                    w_frame_end;
    logic                    w_zero_above;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_digit;
    logic [3:0]              w_code;
    logic                    w_sel_dp;
    logic                    w_blank;
    logic [6:0]              w_seg;
    logic                    w_dp_n;

    // Prescaler tick and frame boundary detection
    always_comb begin
        w_tick      = (r_cnt == CNT_W'(REFRESH_DIV - 1));
        w_frame_end = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    end

    // Leading-zero mask: a digit blanks when it and every digit above it is zero
    always_comb begin
        w_zero_above = 1'b1;
        w_lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_above  = w_zero_above & (r_sh_digits[4*i +: 4] == 4'd0);
            w_lz_blank[i] = w_zero_above & r_sh_lz;
        end
    end

    // Select the scanned digit's code, decimal point and blank condition
    always_comb begin
        w_digit  = '1;
        w_code   = 4'd0;
        w_sel_dp = 1'b0;
        w_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit[i] = 1'b0;
                w_code     = r_sh_digits[4*i +: 4];
                w_sel_dp   = r_sh_dp[i];
                w_blank    = w_lz_blank[i] | (r_phase & r_sh_blink[i]);
            end else begin
                w_digit[i] = 1'b1;
            end
        end
        if (w_blank) begin
            w_seg  = 7'b1111111;
            w_dp_n = 1'b1;
        end else begin
            w_seg  = decode_seg(w_code);
            w_dp_n = ~w_sel_dp;
        end
    end

    // Prescaler, scan index, blink timing and frame-boundary snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
            r_sh_lz     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_frame_end) begin
                r_sh_digits <= digits;
                r_sh_dp     <= dp;
                r_sh_blink  <= blink_mask;
                r_sh_lz     <= lz_en;
                if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FC_W'(1);
                end
            end
        end
    end

    // Registered pin drivers; all change together one cycle after the index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DIGIT       <= '1;
            DISPLAY     <= 7'b1111111;
            DP          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            DIGIT       <= w_digit;
            DISPLAY     <= w_seg;
            DP          <= w_dp_n;
            frame_start <= (r_idx == '0) && (r_cnt == '0);
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: a cycle-position model predicts every
// output edge; expectations are queued before the edge and compared after it.
module tb_seven_segment_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FP = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic        lz_en = 1'b0;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        DP;
    logic        frame_start;

    seven_segment_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blink_mask(blink_mask),
        .lz_en(lz_en), .DIGIT(DIGIT), .DISPLAY(DISPLAY), .DP(DP), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          p = 0;
    logic [15:0] m_dig = 16'h0000;
    logic [3:0]  m_dp = 4'b0000;
    logic [3:0]  m_bl = 4'b0000;
    logic        m_lz = 1'b0;
    logic [12:0] exp_q[$];

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
`ifdef SEVSEG_HEX_EN
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
`endif
            default: return 7'b1111111;
        endcase
    endfunction

    // {DIGIT, DISPLAY, DP, frame_start} for the output edge at position pp
    function automatic logic [12:0] model(input int pp);
        int          d;
        int          ph;
        logic [15:0] upper;
        logic [3:0]  code;
        logic        blank;
        logic [3:0]  one;
        d     = (pp / RD) % ND;
        ph    = ((pp / FP) / BF) % 2;
        upper = m_dig >> (4 * d);
        code  = upper[3:0];
        blank = (m_lz && d >= 1 && upper == 16'h0000) || (ph == 1 && m_bl[d]);
        one   = 4'b0001;
        return {~(one << d), blank ? 7'b1111111 : ref_seg(code),
                blank ? 1'b1 : ~m_dp[d], (pp % FP) == 0};
    endfunction

    task automatic step(input string tag);
        logic [12:0] got;
        logic [12:0] exp;
        exp_q.push_back(model(p));
        if ((p + 1) % FP == 0) begin
            m_dig = digits; m_dp = dp; m_bl = blink_mask; m_lz = lz_en;
        end
        @(posedge clk);
        #1;
        got = {DIGIT, DISPLAY, DP, frame_start};
        exp = exp_q.pop_front();
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s p=%0d observed=%b expected=%b", tag, p, got, exp);
        end
        p++;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic run_until(input int pos, input string tag);
        for (int i = 0; i < 2 * FP && (p % FP) != pos; i++) step(tag);
    endtask

    task automatic check_reset(input string tag);
        logic [12:0] got;
        got = {DIGIT, DISPLAY, DP, frame_start};
        n_vec++;
        assert (got === 13'b1111_1111111_1_0) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, got, 13'b1111_1111111_1_0);
        end
    endtask

    initial begin
        digits = 16'h1234;
        #12;
        check_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        run(3 * FP, "scan_1234");

        digits = 16'h0050; lz_en = 1'b1;
        run(2 * FP, "lz_on_0050");
        lz_en = 1'b0;
        run(2 * FP, "lz_off_0050");

        digits = 16'h1111;
        run(2 * FP, "frame_1111");
        run_until(5, "to_idx1");
        digits = 16'h2222;
        run(2 * FP, "snapshot_2222");

        blink_mask = 4'b0001; dp = 4'b0100;
        run(6 * FP, "blink_dp");
        blink_mask = 4'b0000; dp = 4'b0000;

        digits = 16'hABCD;
        run(2 * FP, "hex_abcd");

        run_until(10, "to_digit2");
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        @(negedge clk);
        p = 0; m_dig = 16'h0000; m_dp = 4'b0000; m_bl = 4'b0000; m_lz = 1'b0;
        digits = 16'h9876;
        rst_n = 1'b1;
        run(3 * FP, "restart_9876");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
